mipi_rx_lane_deskew: RTL and testbench

//  Parametrised successor to the CSI-2 RX lane aligner. Sits between per-lane byte aligners and the packet decoder.

---
 rtl/mipi_rx_lane_deskew_pkg.sv | 30 +++
 rtl/mipi_rx_lane_deskew_if.sv | 37 +++
 rtl/mipi_rx_skew_delay.sv | 46 ++++
 rtl/mipi_rx_lane_deskew.sv | 117 +++++++++++
 tb/tb_mipi_rx_lane_deskew.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_lane_deskew_pkg.sv
// ---------------------------------------------------------------------------
// mipi_rx_pkg : shared types and helpers for the CSI-2 RX lane deskew block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mipi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKEW    = 2'd1,
    ALIGNED = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int MAX_SKEW_DEF = 7;
  localparam int SKEW_W       = clog2(MAX_SKEW_DEF + 1);

endpackage

`default_nettype wire

// File: rtl/mipi_rx_lane_deskew_if.sv
// ---------------------------------------------------------------------------
// mipi_rx_lane_deskew_if : per-lane byte inputs and aligned-word outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mipi_rx_lane_deskew_if
  import mipi_rx_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_SKEW = 7
);

  localparam int SW = clog2(MAX_SKEW + 1);

  logic [LANES-1:0]        lane_en_i;
  logic [LANES-1:0]        bytes_valid_i;
  logic [LANES*DATA_W-1:0] byte_i;
  logic                    lane_valid_o;
  logic [LANES*DATA_W-1:0] lane_byte_o;
  logic [SW-1:0]           skew_o;
  logic                    skew_err_o;

  modport master (
    output lane_en_i, bytes_valid_i, byte_i,
    input  lane_valid_o, lane_byte_o, skew_o, skew_err_o
  );

  modport slave (
    input  lane_en_i, bytes_valid_i, byte_i,
    output lane_valid_o, lane_byte_o, skew_o, skew_err_o
  );

endinterface

`default_nettype wire

// File: rtl/mipi_rx_skew_delay.sv
// ---------------------------------------------------------------------------
// mipi_rx_skew_delay : one-lane {valid,byte} delay line, tap 0 is the live input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mipi_rx_skew_delay #(
  parameter int DATA_W   = 8,
  parameter int MAX_SKEW = 7,
  parameter int TAP_W    = 3
) (
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  input  wire logic              valid_i,
  input  wire logic [DATA_W-1:0] data_i,
  input  wire logic [TAP_W-1:0]  tap_i,
  output logic                   valid_o,
  output logic [DATA_W-1:0]      data_o
);

  logic [DATA_W:0] sr [MAX_SKEW];
  logic [DATA_W:0] sel;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < MAX_SKEW; k++) sr[k] <= '0;
    end else begin
      sr[0] <= {valid_i, data_i};
      for (int k = 1; k < MAX_SKEW; k++) sr[k] <= sr[k-1];
    end
  end

  // sr[k-1] holds the input seen k clocks ago
  always_comb begin
    sel = {valid_i, data_i};
    for (int k = 1; k <= MAX_SKEW; k++) begin
      if (tap_i == TAP_W'(k)) sel = sr[k-1];
    end
  end

  assign valid_o = sel[DATA_W];
  assign data_o  = sel[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mipi_rx_lane_deskew.sv
// ---------------------------------------------------------------------------
// mipi_rx_lane_deskew : measures lane arrival skew, delays early lanes, emits aligned words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mipi_rx_lane_deskew
  import mipi_rx_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_SKEW = 7
) (
  input  wire logic            clk_i,
  input  wire logic            reset_i,
  mipi_rx_lane_deskew_if.slave bus
);

  localparam int SW = clog2(MAX_SKEW + 1);

  state_t                  state, state_nx;
  logic [LANES-1:0]        en_q, arrived_q, en_cur, first_now, arrived_nx, dly_valid;
  logic [SW-1:0]           cnt, skew_q, eff_d;
  logic [SW-1:0]           d_q [LANES];
  logic [SW-1:0]           tap [LANES];
  logic [LANES*DATA_W-1:0] dly_data, word, byte_q;
  logic                    all_dly_valid, complete, drop, timeout, err, emit, valid_q, err_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    mipi_rx_skew_delay #(
      .DATA_W   (DATA_W),
      .MAX_SKEW (MAX_SKEW),
      .TAP_W    (SW)
    ) u_delay (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (bus.bytes_valid_i[n]),
      .data_i  (bus.byte_i[n*DATA_W +: DATA_W]),
      .tap_i   (tap[n]),
      .valid_o (dly_valid[n]),
      .data_o  (dly_data[n*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    en_cur     = (state == IDLE) ? bus.lane_en_i : en_q;
    first_now  = '0;
    if (state == IDLE || state == SKEW) first_now = en_cur & bus.bytes_valid_i & ~arrived_q;
    arrived_nx = arrived_q | first_now;
    complete   = (state == IDLE || state == SKEW) && (en_cur != '0) &&
                 ((arrived_nx & en_cur) == en_cur);
    drop       = (state == SKEW) && ((arrived_q & en_cur & ~bus.bytes_valid_i) != '0);
    timeout    = (state == SKEW) && (cnt == SW'(MAX_SKEW)) && !complete;
    err        = drop || timeout;
    // During the completing cycle the new skew is the live counter value
    eff_d      = (state == ALIGNED) ? skew_q : cnt;
    for (int n = 0; n < LANES; n++) begin
      tap[n] = eff_d - (first_now[n] ? cnt : d_q[n]);
    end
    all_dly_valid = ((dly_valid | ~en_cur) == '1);
    word = '0;
    for (int n = 0; n < LANES; n++) begin
      if (en_cur[n]) word[n*DATA_W +: DATA_W] = dly_data[n*DATA_W +: DATA_W];
    end
    emit = (complete && !err) || (state == ALIGNED && all_dly_valid);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (complete) state_nx = ALIGNED;
               else if (first_now != '0) state_nx = SKEW;
      SKEW:    if (err) state_nx = DRAIN;
               else if (complete) state_nx = ALIGNED;
      ALIGNED: if (!all_dly_valid) state_nx = DRAIN;
      DRAIN:   if (bus.bytes_valid_i == '0) state_nx = IDLE;
      default: state_nx = DRAIN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= DRAIN;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q      <= '0;
      arrived_q <= '0;
      cnt       <= '0;
      skew_q    <= '0;
      valid_q   <= 1'b0;
      byte_q    <= '0;
      err_q     <= 1'b0;
      for (int n = 0; n < LANES; n++) d_q[n] <= '0;
    end else begin
      if (state == IDLE) en_q <= bus.lane_en_i;
      arrived_q <= (state_nx == SKEW) ? arrived_nx : '0;
      cnt       <= (state_nx == SKEW) ? cnt + 1'b1 : '0;
      for (int n = 0; n < LANES; n++) begin
        if (first_now[n]) d_q[n] <= cnt;
      end
      if (complete && !err) skew_q <= cnt;
      valid_q <= emit;
      byte_q  <= emit ? word : '0;
      err_q   <= err;
    end
  end

  assign bus.lane_valid_o = valid_q;
  assign bus.lane_byte_o  = byte_q;
  assign bus.skew_o       = skew_q;
  assign bus.skew_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mipi_rx_lane_deskew.sv
// ---------------------------------------------------------------------------
// tb_mipi_rx_lane_deskew : scenario table expanded into a per-cycle scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mipi_rx_lane_deskew;

  localparam int LANES    = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_SKEW = 7;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mipi_rx_lane_deskew_if #(.LANES(LANES), .DATA_W(DATA_W), .MAX_SKEW(MAX_SKEW)) bus ();

  mipi_rx_lane_deskew #(.LANES(LANES), .DATA_W(DATA_W), .MAX_SKEW(MAX_SKEW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct {
    string          name;
    logic [3:0]     en;
    logic [3:0][7:0] start;
    logic [3:0][7:0] len;
    bit             noise;
    int             rst_at;
    bit             aligned;
    int             skew;
    int             first;
    int             words;
    int             err_at;
  } scen_t;

  typedef struct {
    string       name;
    int          cyc;
    logic        valid;
    logic [31:0] word;
    logic [2:0]  skew;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  logic [2:0] cur_skew    = '0;
  scen_t      tbl[11];

  function automatic logic [7:0] bval(input int i);
    return (i == 0) ? 8'hB8 : 8'(i * 17);
  endfunction

  function automatic scen_t mk(input string name, input logic [3:0] en,
                               input int s0, s1, s2, s3, l0, l1, l2, l3,
                               input bit noise, input int rst_at, input bit aligned,
                               input int skew, first, words, err_at);
    scen_t r;
    r.name = name;  r.en = en;  r.noise = noise;  r.rst_at = rst_at;
    r.start[0] = 8'(s0);  r.start[1] = 8'(s1);  r.start[2] = 8'(s2);  r.start[3] = 8'(s3);
    r.len[0]   = 8'(l0);  r.len[1]   = 8'(l1);  r.len[2]   = 8'(l2);  r.len[3]   = 8'(l3);
    r.aligned = aligned;  r.skew = skew;  r.first = first;  r.words = words;  r.err_at = err_at;
    return r;
  endfunction

  task automatic push_exp(input string name, input int c, input logic v,
                          input logic [31:0] w, input logic e);
    exp_t x;
    x.name = name;  x.cyc = c;  x.valid = v;  x.word = w;  x.skew = cur_skew;  x.err = e;
    sb.push_back(x);
  endtask

  task automatic run_scen(input scen_t sc);
    int          maxend, st, ln;
    logic        v, e;
    logic [31:0] w;
    maxend = 0;
    for (int n = 0; n < LANES; n++) begin
      if (int'(sc.start[n]) + int'(sc.len[n]) > maxend) maxend = int'(sc.start[n]) + int'(sc.len[n]);
    end
    for (int c = 0; c < maxend + 3; c++) begin
      @(negedge clk);
      reset = (c == sc.rst_at);
      bus.lane_en_i = sc.en;
      for (int n = 0; n < LANES; n++) begin
        st = int'(sc.start[n]);
        ln = int'(sc.len[n]);
        if (sc.noise && !sc.en[n]) begin
          bus.bytes_valid_i[n] = (c < maxend) ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.byte_i[n*8 +: 8] = 8'($urandom);
        end else if (c >= st && c < st + ln) begin
          bus.bytes_valid_i[n] = 1'b1;
          bus.byte_i[n*8 +: 8] = bval(c - st);
        end else begin
          bus.bytes_valid_i[n] = 1'b0;
          bus.byte_i[n*8 +: 8] = 8'($urandom);
        end
      end
      v = 1'b0;  w = '0;  e = (c == sc.err_at);
      if (sc.rst_at >= 0 && c >= sc.rst_at) begin
        cur_skew = '0;
        e = 1'b0;
      end else if (sc.aligned && c >= sc.first) begin
        cur_skew = 3'(sc.skew);
        if (c < sc.first + sc.words) begin
          v = 1'b1;
          for (int n = 0; n < LANES; n++) if (sc.en[n]) w[n*8 +: 8] = bval(c - sc.first);
        end
      end
      push_exp(sc.name, c, v, w, e);
    end
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if (bus.lane_valid_o !== mon_e.valid || bus.lane_byte_o !== mon_e.word ||
            bus.skew_o !== mon_e.skew || bus.skew_err_o !== mon_e.err) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got valid=%b word=%h skew=%0d err=%b, expected valid=%b word=%h skew=%0d err=%b",
                   mon_e.name, mon_e.cyc, bus.lane_valid_o, bus.lane_byte_o, bus.skew_o,
                   bus.skew_err_o, mon_e.valid, mon_e.word, mon_e.skew, mon_e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lane_en_i     = 4'hF;
    bus.bytes_valid_i = '0;
    bus.byte_i        = '0;

    //            name            en    starts     lens           nz rst al sk fst wrd err
    tbl[0]  = mk("skewed_start",  4'hF, 5,0,4,4,  10,10,10,10,   0, -1, 1, 5, 5, 10, -1);
    tbl[1]  = mk("all_at_once",   4'hF, 0,0,0,0,   6, 6, 6, 6,   0, -1, 1, 0, 0,  6, -1);
    tbl[2]  = mk("skew_overflow", 4'hF, 0,8,8,8,  12, 4, 4, 4,   0, -1, 0, 0, 0,  0,  7);
    tbl[3]  = mk("after_overflow",4'hF, 1,0,2,3,   5, 5, 5, 5,   0, -1, 1, 3, 3,  5, -1);
    tbl[4]  = mk("half_enabled",  4'h3, 0,2,0,0,   8, 8, 0, 0,   1, -1, 1, 2, 2,  8, -1);
    tbl[5]  = mk("lane1_drop",    4'hF, 5,0,4,4,  10, 6,10,10,   0, -1, 1, 5, 5,  6, -1);
    tbl[6]  = mk("after_drop",    4'hF, 3,0,1,2,   7, 7, 7, 7,   0, -1, 1, 3, 3,  7, -1);
    tbl[7]  = mk("early_drop",    4'hF, 0,0,0,4,   2, 8, 8, 8,   0, -1, 0, 0, 0,  0,  2);
    tbl[8]  = mk("none_enabled",  4'h0, 0,0,0,0,   5, 5, 5, 5,   0, -1, 0, 0, 0,  0, -1);
    tbl[9]  = mk("reset_mid",     4'hF, 0,0,0,0,  10,10,10,10,   0,  4, 1, 0, 0, 10, -1);
    tbl[10] = mk("max_skew",      4'hF, 0,7,3,3,   9, 9, 9, 9,   0, -1, 1, 7, 7,  9, -1);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b1;
      push_exp("reset", c, 1'b0, '0, 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b0;
      push_exp("post_reset", c, 1'b0, '0, 1'b0);
    end

    for (int s = 0; s < 11; s++) run_scen(tbl[s]);

    // Post-reset burst: skew 2 must align cleanly after the reset-time drain
    run_scen(mk("after_reset", 4'hF, 2,2,0,0, 4,4,4,4, 0, -1, 1, 2, 2, 4, -1));

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
